// File: rtl/skinny_sbox_mask_ctrl_if.sv
// Stream-side bundle of the masked S-box controller: unmasked nibbles in, results out, PRNG seed.
interface skinny_sbox_mask_ctrl_if;
  logic [63:0] seed;
  logic        seed_load;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output seed, seed_load, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  seed, seed_load, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/skinny_sbox_mask_ctrl.sv
// Front/back end for a 3-share masked SKINNY-64 S-box pipeline: share splitting, fresh randomness,
// recombination of the delayed share outputs and a credit-controlled result buffer.
module skinny_sbox_mask_ctrl #(
  parameter int unsigned LAT        = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [63:0] SEED_DFLT  = 64'h9E3779B97F4A7C15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  skinny_sbox_mask_ctrl_if.slave bus,
  output logic [3:0]             sh1_o,
  output logic [3:0]             sh2_o,
  output logic [3:0]             sh3_o,
  output logic [11:0]            r_o,
  output logic [3:0]             rc0_o,
  output logic [3:0]             rc1_o,
  output logic [3:0]             klmn_o,
  input  logic [3:0]             sb1_i,
  input  logic [3:0]             sb2_i,
  input  logic [3:0]             sb3_i
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + LAT + 1);

  logic [63:0]    prng_q, prng_d;
  logic [31:0]    unused_prng_hi;
  logic [3:0]     m0, m1;
  logic           accept;
  logic           in_ready;
  logic [LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  credit_used;
  logic [3:0]     fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           push, pop;
  logic [3:0]     push_data;
  logic           out_valid;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // PRNG advances every cycle so no mask is ever presented twice.
  always_comb begin
    prng_d = xorshift64(prng_q);
    if (bus.seed_load) begin
      prng_d = (bus.seed == 64'd0) ? SEED_DFLT : bus.seed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prng_q <= SEED_DFLT;
    else        prng_q <= prng_d;
  end

  assign unused_prng_hi = prng_q[63:32];
  assign m0     = prng_q[3:0];
  assign m1     = prng_q[7:4];
  assign r_o    = prng_q[19:8];
  assign rc0_o  = prng_q[23:20];
  assign rc1_o  = prng_q[27:24];
  assign klmn_o = prng_q[31:28];

  // Idle cycles feed a masked zero so the pipeline never sees unmasked data.
  assign accept = bus.in_valid & in_ready;
  assign sh1_o  = m0;
  assign sh2_o  = m1;
  assign sh3_o  = (accept ? bus.in_data : 4'h0) ^ m0 ^ m1;

  assign tag_d[0] = accept;
  for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
    assign tag_d[gi] = tag_q[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= tag_d;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
  end

  // Every accepted nibble reserves a buffer slot; a same-cycle pop frees it only next cycle.
  assign credit_used  = cnt_q + inflight;
  assign in_ready     = rst_n & (credit_used < CW'(FIFO_DEPTH));
  assign bus.in_ready = in_ready;

  assign push      = tag_q[LAT-1];
  assign push_data = sb1_i ^ sb2_i ^ sb3_i;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = fifo_mem_q[rd_ptr_q];

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(push && (cnt_q == CW'(FIFO_DEPTH))));

endmodule
